// File: rtl/mips_pkg.sv
// Shared encodings for the single-cycle MIPS core: opcodes, functs, control
// enums and the decoded-control bundle passed from controller to datapath.
package mips_pkg;

  localparam logic [31:0] PC_RESET = '0;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_JR    = 6'h08;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLTU, ALU_SLL, ALU_LUI} alu_ctl_e;
  typedef enum logic [2:0] {WB_ALU, WB_MEM, WB_HI, WB_LO, WB_LINK} wb_sel_e;
  typedef enum logic [1:0] {DST_RD, DST_RT, DST_RA} dst_sel_e;
  typedef enum logic [1:0] {PC_SEQ, PC_BEQ, PC_JUMP, PC_JR} pc_sel_e;

  typedef struct packed {
    logic     reg_write;
    dst_sel_e dst;
    logic     alu_imm;
    logic     imm_zext;
    alu_ctl_e alu;
    wb_sel_e  wb;
    logic     mem_write;
    logic     hilo_write;
    pc_sel_e  pc_sel;
  } ctrl_t;

endpackage

// File: rtl/controller.sv
// Main decoder: maps opcode/funct to the datapath control bundle. Anything
// unrecognised falls through to the all-quiet default (PC+4, no writes).
module controller
  import mips_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output ctrl_t      ctl
);

  always_comb begin
    ctl = '{reg_write: 1'b0, dst: DST_RD, alu_imm: 1'b0, imm_zext: 1'b0,
            alu: ALU_ADD, wb: WB_ALU, mem_write: 1'b0, hilo_write: 1'b0,
            pc_sel: PC_SEQ};
    case (op)
      OP_RTYPE: begin
        case (funct)
          F_ADDU:  begin ctl.reg_write = 1'b1; ctl.alu = ALU_ADD;  end
          F_SUBU:  begin ctl.reg_write = 1'b1; ctl.alu = ALU_SUB;  end
          F_AND:   begin ctl.reg_write = 1'b1; ctl.alu = ALU_AND;  end
          F_OR:    begin ctl.reg_write = 1'b1; ctl.alu = ALU_OR;   end
          F_SLTU:  begin ctl.reg_write = 1'b1; ctl.alu = ALU_SLTU; end
          F_SLL:   begin ctl.reg_write = 1'b1; ctl.alu = ALU_SLL;  end
          F_MULTU: ctl.hilo_write = 1'b1;
          F_MFHI:  begin ctl.reg_write = 1'b1; ctl.wb = WB_HI; end
          F_MFLO:  begin ctl.reg_write = 1'b1; ctl.wb = WB_LO; end
          F_JR:    ctl.pc_sel = PC_JR;
          default: ;
        endcase
      end
      OP_ADDIU: begin
        ctl.reg_write = 1'b1; ctl.dst = DST_RT; ctl.alu_imm = 1'b1;
      end
      OP_ORI: begin
        ctl.reg_write = 1'b1; ctl.dst = DST_RT; ctl.alu_imm = 1'b1;
        ctl.imm_zext = 1'b1; ctl.alu = ALU_OR;
      end
      OP_LUI: begin
        ctl.reg_write = 1'b1; ctl.dst = DST_RT; ctl.alu = ALU_LUI;
      end
      OP_LW: begin
        ctl.reg_write = 1'b1; ctl.dst = DST_RT; ctl.alu_imm = 1'b1; ctl.wb = WB_MEM;
      end
      OP_SW: begin
        ctl.alu_imm = 1'b1; ctl.mem_write = 1'b1;
      end
      OP_BEQ: ctl.pc_sel = PC_BEQ;
      OP_J:   ctl.pc_sel = PC_JUMP;
      OP_JAL: begin
        ctl.pc_sel = PC_JUMP; ctl.reg_write = 1'b1; ctl.dst = DST_RA; ctl.wb = WB_LINK;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/datapath.sv
// Single-cycle datapath: PC, register file, inline ALU, HI/LO and data RAM.
// PC and HI/LO reset asynchronously; GPRs and data RAM are never cleared.
module datapath
  import mips_pkg::*;
#(
  parameter int DMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  ctrl_t       ctl,
  input  logic [25:0] instr_lo,
  output logic [29:0] pc_word
);

  localparam int DAW = $clog2(DMEM_WORDS);

  logic [31:0] pc_q, pc_d, hi_q, hi_d, lo_q, lo_d;
  logic [31:0] dmem [DMEM_WORDS-1:0];

  logic [4:0]  rs, rt, rd, shamt, wa;
  logic [15:0] imm;
  logic [31:0] imm_ext, imm_sext, rs_val, rt_val, alu_b, alu_y, wd, pc4;
  logic [63:0] product;
  logic        rf_we, mem_we;

  regfile gpr (
    .clk (clk),
    .we  (rf_we),
    .ra1 (rs),
    .ra2 (rt),
    .wa  (wa),
    .wd  (wd),
    .rd1 (rs_val),
    .rd2 (rt_val)
  );

  always_comb begin
    rs       = instr_lo[25:21];
    rt       = instr_lo[20:16];
    rd       = instr_lo[15:11];
    shamt    = instr_lo[10:6];
    imm      = instr_lo[15:0];
    imm_sext = {{16{imm[15]}}, imm};
    imm_ext  = ctl.imm_zext ? {16'h0000, imm} : imm_sext;
    alu_b    = ctl.alu_imm ? imm_ext : rt_val;
    pc4      = pc_q + 32'd4;
    product  = 64'(rs_val) * 64'(rt_val);

    case (ctl.alu)
      ALU_ADD:  alu_y = rs_val + alu_b;
      ALU_SUB:  alu_y = rs_val - alu_b;
      ALU_AND:  alu_y = rs_val & alu_b;
      ALU_OR:   alu_y = rs_val | alu_b;
      ALU_SLTU: alu_y = {31'b0, rs_val < alu_b};
      ALU_SLL:  alu_y = rt_val << shamt;
      ALU_LUI:  alu_y = {imm, 16'h0000};
      default:  alu_y = '0;
    endcase

    case (ctl.dst)
      DST_RT:  wa = rt;
      DST_RA:  wa = 5'd31;
      default: wa = rd;
    endcase

    case (ctl.wb)
      WB_MEM:  wd = dmem[alu_y[DAW+1:2]];
      WB_HI:   wd = hi_q;
      WB_LO:   wd = lo_q;
      WB_LINK: wd = pc4;
      default: wd = alu_y;
    endcase

    // Architectural writes are suppressed while reset is held so that
    // externally preloaded GPR/RAM contents survive the reset window.
    rf_we  = ctl.reg_write & reset;
    mem_we = ctl.mem_write & reset;

    case (ctl.pc_sel)
      PC_BEQ:  pc_d = (rs_val == rt_val) ? pc4 + {imm_sext[29:0], 2'b00} : pc4;
      PC_JUMP: pc_d = {pc4[31:28], instr_lo, 2'b00};
      PC_JR:   pc_d = rs_val;
      default: pc_d = pc4;
    endcase

    hi_d = hi_q;
    lo_d = lo_q;
    if (ctl.hilo_write) {hi_d, lo_d} = product;

    pc_word = pc_q[31:2];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= PC_RESET;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      pc_q <= pc_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) dmem[alu_y[DAW+1:2]] <= rt_val;
  end

endmodule

// File: rtl/instr_rom.sv
// Instruction ROM, loaded hierarchically through INSTRROM; addresses beyond
// the array read as zero, which decodes as a NOP.
module instr_rom #(
  parameter int IMEM_WORDS = 64
) (
  input  logic [29:0] word_addr,
  output logic [31:0] instr
);

  localparam int IAW = $clog2(IMEM_WORDS);

  logic [31:0] INSTRROM [IMEM_WORDS-1:0];

  always_comb begin
    instr = '0;
    if (word_addr < 30'(IMEM_WORDS)) instr = INSTRROM[word_addr[IAW-1:0]];
  end

endmodule

// File: rtl/mips_core.sv
// Core wrapper: decoder plus datapath; consumes the fetched instruction and
// exposes the PC word address to the instruction ROM.
module mips_core
  import mips_pkg::*;
#(
  parameter int DMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  output logic [29:0] pc_word
);

  ctrl_t ctl;

  controller ctrl (
    .op    (instr[31:26]),
    .funct (instr[5:0]),
    .ctl   (ctl)
  );

  datapath #(.DMEM_WORDS(DMEM_WORDS)) dp (
    .clk      (clk),
    .reset    (reset),
    .ctl      (ctl),
    .instr_lo (instr[25:0]),
    .pc_word  (pc_word)
  );

endmodule

// File: rtl/regfile.sv
// 32x32 register file: two combinational read ports, one synchronous write
// port; $0 reads as zero and ignores writes. Contents are never reset.
module regfile (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] registers [31:0];

  always_ff @(posedge clk) begin
    if (we && (wa != 5'd0)) registers[wa] <= wd;
  end

  always_comb begin
    rd1 = (ra1 == 5'd0) ? '0 : registers[ra1];
    rd2 = (ra2 == 5'd0) ? '0 : registers[ra2];
  end

endmodule

// File: rtl/mips_processor.sv
// Single-cycle MIPS top: instruction ROM plus core. Programs are loaded and
// results inspected hierarchically; there are no external buses.
module mips_processor #(
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_WORDS = 64
) (
  input  logic clk,
  input  logic reset
);

  logic [31:0] instr;
  logic [29:0] pc_word;

  instr_rom #(.IMEM_WORDS(IMEM_WORDS)) imem (
    .word_addr (pc_word),
    .instr     (instr)
  );

  mips_core #(.DMEM_WORDS(DMEM_WORDS)) mips (
    .clk     (clk),
    .reset   (reset),
    .instr   (instr),
    .pc_word (pc_word)
  );

endmodule

// File: tb/tb_mips_processor.sv
// Directed self-checking bench for mips_processor: hand-assembled programs
// with hand-computed register, HI/LO and PC results.
module tb_mips_processor;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;

  mips_processor #(.IMEM_WORDS(64), .DMEM_WORDS(64)) dut (
    .clk   (clk),
    .reset (reset)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  // Holds reset low, clears ROM and presets every GPR (except $0) to val.
  task automatic begin_program(input logic [31:0] val);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 64; i++) dut.imem.INSTRROM[i] = 32'h0;
    dut.mips.dp.gpr.registers[0] = 32'h0;
    for (int i = 1; i < 32; i++) dut.mips.dp.gpr.registers[i] = val;
  endtask

  task automatic run(input int n);
    @(negedge clk);
    reset = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reg(input string name, input int r, input logic [31:0] exp);
    logic [31:0] got;
    got = dut.mips.dp.gpr.registers[r];
    tests++;
    if (got !== exp) begin
      $display("FAIL %s r%0d got %h exp %h", name, r, got, exp);
      fails++;
    end
  endtask

  task automatic test_reset;
    #12;
    tests++;
    if (dut.mips.dp.pc_q !== 32'h0) begin
      $display("FAIL reset_pc got %h exp %h", dut.mips.dp.pc_q, 32'h0); fails++;
    end
    tests++;
    if (dut.mips.dp.hi_q !== 32'h0) begin
      $display("FAIL reset_hi got %h exp %h", dut.mips.dp.hi_q, 32'h0); fails++;
    end
    tests++;
    if (dut.mips.dp.lo_q !== 32'h0) begin
      $display("FAIL reset_lo got %h exp %h", dut.mips.dp.lo_q, 32'h0); fails++;
    end
  endtask

  task automatic test_constants;
    begin_program(32'hcafebabe);
    dut.imem.INSTRROM[0] = enc_i(6'h0F, 5'd0, 5'd1, 16'h1234);
    dut.imem.INSTRROM[1] = enc_i(6'h0D, 5'd1, 5'd1, 16'h5678);
    run(6);
    chk_reg("const", 1, 32'h12345678);
    for (int r = 2; r < 32; r++) chk_reg("const_keep", r, 32'hcafebabe);
  endtask

  task automatic test_alu;
    begin_program(32'hcafebabe);
    dut.imem.INSTRROM[0]  = enc_i(6'h09, 5'd0, 5'd2, 16'hFFFF);
    dut.imem.INSTRROM[1]  = enc_i(6'h09, 5'd0, 5'd3, 16'h0001);
    dut.imem.INSTRROM[2]  = enc_r(5'd2, 5'd3, 5'd4, 5'd0, 6'h21);
    dut.imem.INSTRROM[3]  = enc_r(5'd3, 5'd2, 5'd5, 5'd0, 6'h23);
    dut.imem.INSTRROM[4]  = enc_r(5'd3, 5'd2, 5'd6, 5'd0, 6'h2B);
    dut.imem.INSTRROM[5]  = enc_i(6'h0F, 5'd0, 5'd7, 16'hF0F0);
    dut.imem.INSTRROM[6]  = enc_i(6'h0D, 5'd7, 5'd7, 16'hF0F0);
    dut.imem.INSTRROM[7]  = enc_i(6'h0F, 5'd0, 5'd8, 16'h0FF0);
    dut.imem.INSTRROM[8]  = enc_i(6'h0D, 5'd8, 5'd8, 16'h0FF0);
    dut.imem.INSTRROM[9]  = enc_r(5'd7, 5'd8, 5'd9, 5'd0, 6'h24);
    dut.imem.INSTRROM[10] = enc_r(5'd7, 5'd8, 5'd10, 5'd0, 6'h25);
    dut.imem.INSTRROM[11] = enc_r(5'd2, 5'd3, 5'd11, 5'd0, 6'h2B);
    dut.imem.INSTRROM[12] = enc_r(5'd0, 5'd3, 5'd12, 5'd31, 6'h00);
    dut.imem.INSTRROM[13] = enc_i(6'h2B, 5'd3, 5'd10, 16'h0007);
    dut.imem.INSTRROM[14] = enc_i(6'h09, 5'd0, 5'd14, 16'h0020);
    dut.imem.INSTRROM[15] = enc_i(6'h23, 5'd14, 5'd15, 16'hFFE8);
    dut.imem.INSTRROM[16] = enc_i(6'h23, 5'd0, 5'd13, 16'h0008);
    run(20);
    chk_reg("alu_lim", 2, 32'hFFFFFFFF);
    chk_reg("addu", 4, 32'h00000000);
    chk_reg("subu", 5, 32'h00000002);
    chk_reg("sltu_t", 6, 32'h00000001);
    chk_reg("ori_zext", 7, 32'hF0F0F0F0);
    chk_reg("and", 9, 32'h00F000F0);
    chk_reg("or", 10, 32'hFFF0FFF0);
    chk_reg("sltu_f", 11, 32'h00000000);
    chk_reg("sll", 12, 32'h80000000);
    chk_reg("lw_pos", 13, 32'hFFF0FFF0);
    chk_reg("lw_neg", 15, 32'hFFF0FFF0);
    chk_reg("alu_keep", 16, 32'hcafebabe);
  endtask

  task automatic test_multiply;
    begin_program(32'hcafebabe);
    dut.mips.dp.gpr.registers[10] = 32'h0;
    dut.imem.INSTRROM[0]  = enc_i(6'h09, 5'd10, 5'd10, 16'h0001);
    dut.imem.INSTRROM[1]  = enc_i(6'h0F, 5'd0, 5'd1, 16'h0001);
    dut.imem.INSTRROM[2]  = enc_i(6'h0F, 5'd0, 5'd2, 16'h0003);
    dut.imem.INSTRROM[3]  = enc_r(5'd1, 5'd2, 5'd0, 5'd0, 6'h19);
    dut.imem.INSTRROM[4]  = enc_r(5'd0, 5'd0, 5'd3, 5'd0, 6'h10);
    dut.imem.INSTRROM[5]  = enc_r(5'd0, 5'd0, 5'd4, 5'd0, 6'h12);
    dut.imem.INSTRROM[6]  = enc_i(6'h09, 5'd0, 5'd5, 16'hFFFF);
    dut.imem.INSTRROM[7]  = enc_r(5'd5, 5'd5, 5'd0, 5'd0, 6'h19);
    dut.imem.INSTRROM[8]  = enc_r(5'd0, 5'd0, 5'd6, 5'd0, 6'h10);
    dut.imem.INSTRROM[9]  = enc_r(5'd0, 5'd0, 5'd7, 5'd0, 6'h12);
    dut.imem.INSTRROM[10] = enc_r(5'd1, 5'd2, 5'd8, 5'd0, 6'h3F);
    dut.imem.INSTRROM[11] = enc_i(6'h3F, 5'd1, 5'd8, 16'h1234);
    dut.imem.INSTRROM[12] = enc_r(5'd0, 5'd0, 5'd9, 5'd0, 6'h12);
    dut.imem.INSTRROM[13] = enc_i(6'h09, 5'd0, 5'd11, 16'h0100);
    dut.imem.INSTRROM[14] = enc_r(5'd11, 5'd0, 5'd0, 5'd0, 6'h08);
    run(20);
    chk_reg("mfhi", 3, 32'h00000003);
    chk_reg("mflo", 4, 32'h00000000);
    chk_reg("mfhi_max", 6, 32'hFFFFFFFE);
    chk_reg("mflo_max", 7, 32'h00000001);
    chk_reg("unknown_keep", 8, 32'hcafebabe);
    chk_reg("lo_after_unknown", 9, 32'h00000001);
    chk_reg("oor_nop", 10, 32'h00000001);
    tests++;
    if (dut.mips.dp.pc_q !== 32'h00000114) begin
      $display("FAIL oor_pc got %h exp %h", dut.mips.dp.pc_q, 32'h00000114); fails++;
    end
  endtask

  task automatic test_call_return;
    begin_program(32'h0);
    dut.imem.INSTRROM[0] = enc_j(6'h03, 26'h3);
    dut.imem.INSTRROM[1] = enc_i(6'h09, 5'd0, 5'd2, 16'h0007);
    dut.imem.INSTRROM[2] = enc_j(6'h02, 26'h2);
    dut.imem.INSTRROM[3] = enc_i(6'h09, 5'd0, 5'd3, 16'h0005);
    dut.imem.INSTRROM[4] = enc_r(5'd31, 5'd0, 5'd0, 5'd0, 6'h08);
    run(8);
    chk_reg("jal_link", 31, 32'h00000004);
    chk_reg("callee", 3, 32'h00000005);
    chk_reg("ret", 2, 32'h00000007);
    tests++;
    if (dut.mips.dp.pc_q !== 32'h00000008) begin
      $display("FAIL j_loop_pc got %h exp %h", dut.mips.dp.pc_q, 32'h00000008); fails++;
    end
  endtask

  task automatic test_fibonacci;
    begin_program(32'h00005555);
    dut.imem.INSTRROM[0]  = enc_i(6'h09, 5'd0, 5'd1, 16'h0000);
    dut.imem.INSTRROM[1]  = enc_i(6'h09, 5'd0, 5'd2, 16'h0001);
    dut.imem.INSTRROM[2]  = enc_i(6'h09, 5'd0, 5'd4, 16'h0008);
    dut.imem.INSTRROM[3]  = enc_i(6'h09, 5'd0, 5'd0, 16'h0009);
    dut.imem.INSTRROM[4]  = enc_i(6'h04, 5'd4, 5'd0, 16'h0005);
    dut.imem.INSTRROM[5]  = enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h21);
    dut.imem.INSTRROM[6]  = enc_r(5'd0, 5'd2, 5'd1, 5'd0, 6'h21);
    dut.imem.INSTRROM[7]  = enc_r(5'd0, 5'd3, 5'd2, 5'd0, 6'h21);
    dut.imem.INSTRROM[8]  = enc_i(6'h09, 5'd4, 5'd4, 16'hFFFF);
    dut.imem.INSTRROM[9]  = enc_j(6'h02, 26'h4);
    dut.imem.INSTRROM[10] = enc_i(6'h09, 5'd0, 5'd10, 16'h0003);
    dut.imem.INSTRROM[11] = enc_j(6'h02, 26'hB);
    run(70);
    chk_reg("fib_a", 1, 32'd21);
    chk_reg("fib_b", 2, 32'd34);
    chk_reg("fib_sum", 3, 32'd34);
    chk_reg("fib_cnt", 4, 32'd0);
    chk_reg("fib_done", 10, 32'd3);
    chk_reg("zero_reg", 0, 32'd0);
    tests++;
    if (dut.mips.dp.pc_q !== 32'h0000002C) begin
      $display("FAIL fib_pc got %h exp %h", dut.mips.dp.pc_q, 32'h0000002C); fails++;
    end
  endtask

  task automatic test_reset_midrun;
    begin_program(32'h0);
    dut.mips.dp.gpr.registers[5] = 32'd100;
    dut.imem.INSTRROM[0] = enc_i(6'h0F, 5'd0, 5'd1, 16'h0002);
    dut.imem.INSTRROM[1] = enc_r(5'd1, 5'd1, 5'd0, 5'd0, 6'h19);
    dut.imem.INSTRROM[2] = enc_i(6'h09, 5'd5, 5'd5, 16'h0001);
    dut.imem.INSTRROM[3] = enc_j(6'h02, 26'h3);
    run(6);
    chk_reg("pre_rst", 5, 32'd101);
    tests++;
    if (dut.mips.dp.hi_q !== 32'h4) begin
      $display("FAIL pre_rst_hi got %h exp %h", dut.mips.dp.hi_q, 32'h4); fails++;
    end
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    tests++;
    if (dut.mips.dp.pc_q !== 32'h0) begin
      $display("FAIL async_pc got %h exp %h", dut.mips.dp.pc_q, 32'h0); fails++;
    end
    tests++;
    if (dut.mips.dp.hi_q !== 32'h0) begin
      $display("FAIL async_hi got %h exp %h", dut.mips.dp.hi_q, 32'h0); fails++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk_reg("in_rst_keep", 5, 32'd101);
    tests++;
    if (dut.mips.dp.pc_q !== 32'h0) begin
      $display("FAIL held_pc got %h exp %h", dut.mips.dp.pc_q, 32'h0); fails++;
    end
    run(6);
    chk_reg("rerun", 5, 32'd102);
    tests++;
    if (dut.mips.dp.hi_q !== 32'h4) begin
      $display("FAIL rerun_hi got %h exp %h", dut.mips.dp.hi_q, 32'h4); fails++;
    end
    tests++;
    if (dut.mips.dp.pc_q !== 32'h0000000C) begin
      $display("FAIL rerun_pc got %h exp %h", dut.mips.dp.pc_q, 32'h0000000C); fails++;
    end
  endtask

  initial begin
    test_reset();
    test_constants();
    test_alu();
    test_multiply();
    test_call_return();
    test_fibonacci();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
